// File: rtl/add_round_key_stage.sv
// add_round_key_stage: registered AES-128 AddRoundKey stage with an on-the-fly
// key schedule that advances one round key per accepted state.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset_n    - synchronous active-low reset
//   key_load   - pulse: capture key_in as the cipher key
//   key_in     - 128-bit cipher key, byte 4c+r = row r of column c (byte 0 is MSB)
//   key_valid  - a cipher key is loaded
//   in_valid   - in_data holds a state
//   in_ready   - combinational: stage accepts in_data this cycle
//   in_data    - state from the preceding stage
//   out_valid  - out_data holds a keyed state
//   out_ready  - downstream consumes out_data this cycle
//   out_data   - in_data ^ round_key[out_round]
//   out_round  - round index (0..10) of the key applied to out_data

package add_round_key_stage_pkg;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned ROUND_W = 4;
    typedef logic [STATE_W-1:0] state_t;
endpackage

module add_round_key_stage
    import add_round_key_stage_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               key_load,
    input  state_t             key_in,
    output logic               key_valid,
    input  logic               in_valid,
    output logic               in_ready,
    input  state_t             in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output state_t             out_data,
    output logic [ROUND_W-1:0] out_round
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(10);

    // FIPS-197 forward S-box, index 0 is leftmost
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t             base_key;
    state_t             cur_key;
    logic [ROUND_W-1:0] round;
    state_t             next_key;
    logic [7:0]         rcon;
    logic               xfer;

    // S-box applied to each byte of a word
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // One AES-128 key-schedule step; word 0 occupies the top 32 bits
    function automatic state_t expand(input state_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        expand = {w0, w1, w2, w3};
    endfunction

    // Rcon for the round key that follows the current one
    always_comb begin
        rcon = 8'h00;
        case (round)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        next_key = expand(cur_key, rcon);
    end

    // Key load wins over a transfer; backpressure blocks new input
    assign in_ready = key_valid & ~key_load & (~out_valid | out_ready);
    assign xfer     = in_valid & in_ready;

    // Key schedule and output register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            base_key  <= '0;
            cur_key   <= '0;
            round     <= '0;
            key_valid <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_round <= '0;
        end else begin
            if (key_load) begin
                base_key  <= key_in;
                cur_key   <= key_in;
                round     <= '0;
                key_valid <= 1'b1;
            end else if (xfer) begin
                // After round 10 rewind to the cipher key so the next block needs no reload
                if (round >= LAST_ROUND) begin
                    cur_key <= base_key;
                    round   <= '0;
                end else begin
                    cur_key <= next_key;
                    round   <= ROUND_W'(round + ROUND_W'(1));
                end
            end

            if (xfer) begin
                out_data  <= in_data ^ cur_key;
                out_round <= round;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add_round_key_stage.sv
module tb_add_round_key_stage;
    import add_round_key_stage_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       key_load;
    state_t     key_in;
    logic       key_valid;
    logic       in_valid;
    logic       in_ready;
    state_t     in_data;
    logic       out_valid;
    logic       out_ready;
    state_t     out_data;
    logic [3:0] out_round;

    add_round_key_stage dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_valid (key_valid),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_round (out_round)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        state_t     d;
        logic [3:0] r;
    } exp_t;

    typedef struct {
        state_t     din;
        state_t     dout;
        logic [3:0] rnd;
    } vec_t;

    exp_t   q[$];
    vec_t   vecs[13];
    state_t rk[11];

    int n_cmp = 0;
    int n_err = 0;

    localparam state_t KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam state_t KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam state_t KEY2_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam state_t PT0 = 128'h3243f6a8885a308d313198a2e0370734;

    task automatic chk(input string name, input state_t act, input state_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on every consumption of out_data
    always @(negedge clock) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h round %0d, expected none", out_data, out_round);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_round", state_t'(out_round), state_t'(e.r));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a state and record its expected result when it is accepted
    task automatic send(input state_t d, input state_t ed, input logic [3:0] er);
        bit done;
        done = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (in_ready === 1'b1) begin
                q.push_back('{ed, er});
                done = 1'b1;
            end
            step();
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no in_ready, expected acceptance of %h", d);
        end
    endtask

    task automatic load(input state_t k);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clock);
        chk("in_ready_during_load", state_t'(in_ready), state_t'(1'b0));
        step();
        key_load = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("key_valid_after_load", state_t'(key_valid), state_t'(1'b1));
        step();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (q.size() == 0 && out_valid === 1'b0) done = 1'b1;
            step();
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
    endtask

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[0] = '{PT0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0};
        vecs[1] = '{128'h046681e5e0cb199a48f8d37a2806264c,
                    128'ha49c7ff2689f352b6b5bea43026a5049, 4'd1};
        for (int i = 2; i <= 10; i++) vecs[i] = '{'0, rk[i], 4'(i)};
        vecs[11] = '{'0, rk[0], 4'd0};
        vecs[12] = '{'0, rk[1], 4'd1};

        reset_n   = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;

        // Reset state
        @(negedge clock);
        chk("rst_in_ready", state_t'(in_ready), '0);
        chk("rst_key_valid", state_t'(key_valid), '0);
        chk("rst_out_valid", state_t'(out_valid), '0);
        chk("rst_out_round", state_t'(out_round), '0);
        chk("rst_out_data", out_data, '0);
        step();

        // No key loaded: input is ignored
        in_valid = 1'b1;
        in_data  = PT0;
        repeat (3) step();
        @(negedge clock);
        chk("nokey_in_ready", state_t'(in_ready), '0);
        chk("nokey_out_valid", state_t'(out_valid), '0);
        step();
        in_valid = 1'b0;

        // FIPS-197 vectors back to back, including the round-10 wrap
        load(KEY1);
        for (int i = 0; i < 13; i++) send(vecs[i].din, vecs[i].dout, vecs[i].rnd);
        drain();

        // Fresh key: 12 zero states return the key schedule, then wrap
        load(KEY1);
        for (int i = 0; i < 12; i++) send('0, rk[i % 11], 4'(i % 11));
        drain();

        // Backpressure at round 1
        out_ready = 1'b0;
        send(PT0, PT0 ^ rk[1], 4'd1);
        in_data  = 128'h0123456789abcdeffedcba9876543210;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_in_ready", state_t'(in_ready), '0);
            chk("bp_out_valid", state_t'(out_valid), state_t'(1'b1));
            chk("bp_out_data", out_data, PT0 ^ rk[1]);
            chk("bp_out_round", state_t'(out_round), state_t'(4'd1));
            step();
        end
        out_ready = 1'b1;
        send(128'h0123456789abcdeffedcba9876543210,
             128'h0123456789abcdeffedcba9876543210 ^ rk[2], 4'd2);
        send('0, rk[3], 4'd3);
        send('0, rk[4], 4'd4);
        drain();

        // Key load at round 5 with a competing input
        in_data  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        in_valid = 1'b1;
        load(KEY2);
        chk("kl_no_xfer_out_valid", state_t'(out_valid), '0);
        send('0, KEY2, 4'd0);
        send('0, KEY2_RK1, 4'd1);
        drain();

        // Reset at round 5 discards the key
        load(KEY1);
        for (int i = 0; i < 5; i++) send('0, rk[i], 4'(i));
        drain();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = PT0;
        step();
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst2_key_valid", state_t'(key_valid), '0);
        chk("rst2_in_ready", state_t'(in_ready), '0);
        chk("rst2_out_valid", state_t'(out_valid), '0);
        chk("rst2_out_data", out_data, '0);
        chk("rst2_out_round", state_t'(out_round), '0);
        step();
        repeat (3) step();
        @(negedge clock);
        chk("rst2_hold_out_valid", state_t'(out_valid), '0);
        step();
        in_valid = 1'b0;
        load(KEY1);
        send(PT0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0);
        drain();
        chk("queue_empty", state_t'(q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/add_round_key_stage.md
# add_round_key_stage

Registered AddRoundKey stage of the AES-128 encryption round. It sits directly downstream of MixColumns, or of ShiftRows in round 10 and of the plaintext input in round 0. It XORs each accepted state with the correct round key. The round keys come from an internal iterative key-expansion unit that advances one round key per accepted state, so no precomputed key storage is needed. Valid/ready handshakes on both sides; one state per cycle sustained throughput.

## Interface
- No parameters; AES-128 only (16-byte `state_t`, 11 round keys).
- `clock`  in  1  sole clock, all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `key_load`  in  1  single-cycle pulse: capture `key_in` as the cipher key.
- `key_in`  in  state_t  128-bit cipher key; byte 4c+r is row r of column c.
- `key_valid`  out  1  a cipher key is loaded; round keys are available.
- `in_valid`  in  1  `in_data` holds a state to be keyed.
- `in_ready`  out  1  stage accepts `in_data` this cycle.
- `in_data`  in  state_t  state from the preceding stage; same byte layout as `key_in`.
- `out_valid`  out  1  `out_data` holds a keyed state.
- `out_ready`  in  1  downstream consumes `out_data` this cycle.
- `out_data`  out  state_t  `in_data ^ round_key[r]`.
- `out_round`  out  4  round index r (0..10) of the key applied to `out_data`.

## Operation
- Registers:
  - `base_key`: the cipher key.
  - `cur_key`: the round key for the next accepted state.
  - `round`: 4-bit, 0..10.
  - `key_valid`, the output register (`out_data`, `out_round`, `out_valid`).
- Key load: when `key_load`=1, then on the next edge `base_key` ← `key_in`, `cur_key` ← `key_in`, `round` ← 0, `key_valid` ← 1. The output register is unaffected, so a pending output is not flushed.
- `in_ready` = `key_valid` & !`key_load` & (!`out_valid` | `out_ready`). This is combinational. `key_load` takes priority over an input transfer in the same cycle.
- Transfer (`in_valid` & `in_ready`):
  - `out_data` ← `in_data ^ cur_key`; `out_round` ← `round`; `out_valid` ← 1.
  - If `round` < 10: `cur_key` ← Expand(`cur_key`, Rcon[`round`+1]) and `round` ← `round`+1.
  - If `round` = 10: `cur_key` ← `base_key` and `round` ← 0. This wrap lets the next block reuse the same cipher key without a reload.
- Output drain: if `out_valid` & `out_ready` and there is no transfer, then `out_valid` ← 0. A simultaneous drain and transfer keeps `out_valid`=1 with the new data.
- Expand(k, rc): the key is split into words w0..w3, where word c is bytes 4c..4c+3 and byte 4c is the most significant.
  - t = SubWord(RotWord(w3)) ^ {rc, 00, 00, 00}. RotWord maps [a0,a1,a2,a3] → [a1,a2,a3,a0].
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- SubWord applies the FIPS-197 forward S-box per byte. The S-box is a local 256-entry combinational lookup table.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- All arithmetic is XOR / GF(2^8); there are no carries. `round` never holds values 11..15.
- Reset (`reset_n`=0 at an edge) takes priority over everything:
  - `key_valid`, `out_valid` ← 0; `out_data`, `out_round`, `base_key`, `cur_key`, `round` ← 0.
  - `in_ready` is therefore 0 from the first cycle after reset.
  - Reset mid-block discards the in-flight round sequence; a new `key_load` is required.
- `key_load` mid-block (`round` ≠ 0) abandons the current sequence. The next accepted state gets round 0 of the new key.
- With `key_valid`=0, `in_valid` is ignored and `in_ready`=0.

## Timing
- Latency: 1 cycle from an accepted input to `out_valid`.
- Throughput: one state per cycle while `out_ready`=1.
- `key_load` in cycle t → `key_valid`=1 and `in_ready` can be 1 in cycle t+1.
- Key expansion is a single-cycle combinational path from `cur_key` (RotWord → S-box → XOR chain) into the `cur_key` register.
- Backpressure: when `out_valid`=1 and `out_ready`=0, `in_ready`=0. `out_data` and `out_round` hold stable until consumed.
- `in_valid` may drop without a transfer. The key schedule advances only on a transfer.

## Test plan
- Reset → `in_ready`=0, `key_valid`=0, `out_valid`=0, `out_round`=0. Assert `in_valid`=1 with no key loaded → no transfer, outputs unchanged.
- Load key 2b7e151628aed2a6abf7158809cf4f3c, send 3243f6a8885a308d313198a2e0370734 → one cycle later `out_data`=193de3bea0f4e22b9ac68d2ae9f84808, `out_round`=0.
- Round 1: send 046681e5e0cb199a48f8d37a2806264c → `out_data`=a49c7ff2689f352b6b5bea43026a5049, `out_round`=1.
- Back-to-back 11 zero states with `out_ready`=1 → `out_data` sequence equals the 11 FIPS-197 round keys, ending in d014f9a8c9ee2589e13f0cc8b6630ca6 at `out_round`=10. A 12th zero state returns 2b7e…4f3c at `out_round`=0 (wrap).
- Backpressure: hold `out_ready`=0 for 3 cycles after a transfer → `in_ready`=0 and `out_data` stable. Release → drain and the next transfer occur in the same cycle, with no lost or duplicated round.
- `key_load` asserted with `in_valid`=1 in the same cycle at `round`=5 → no transfer. The next accepted state gets `out_round`=0 keyed with the new key. Repeat at `round`=5 with `reset_n`=0 → all outputs 0 and a reload is required.
